// File: rtl/decode_hazard_scoreboard_if.sv
// rtl/decode_hazard_scoreboard_if.sv - decode/writeback/drain signal bundle for the hazard scoreboard
interface decode_hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 16
);
    logic                id_valid;
    logic [ADDR_W-1:0]   id_rs;
    logic [ADDR_W-1:0]   id_rt;
    logic                id_use_rt;
    logic [ADDR_W-1:0]   id_rd;
    logic                id_reg_write;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_addr;
    logic                drain_req;
    logic                id_issue;
    logic                id_stall;
    logic [NUM_REGS-1:0] pending;
    logic [ADDR_W:0]     outstanding;
    logic                drain_done;
    logic [CNT_W-1:0]    stall_cycles;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rt, id_rd, id_reg_write,
        output wb_valid, wb_addr, drain_req,
        input  id_issue, id_stall, pending, outstanding, drain_done, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rt, id_rd, id_reg_write,
        input  wb_valid, wb_addr, drain_req,
        output id_issue, id_stall, pending, outstanding, drain_done, stall_cycles
    );
endinterface

// File: rtl/decode_hazard_scoreboard.sv
// rtl/decode_hazard_scoreboard.sv - register scoreboard with RAW/WAW stall and drain control
module decode_hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    decode_hazard_scoreboard_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [ADDR_W:0]     outstanding_q, outstanding_d;
    logic                drain_done_q, drain_done_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

    logic [NUM_REGS-1:0] clr;
    logic [NUM_REGS-1:0] set;
    logic [NUM_REGS-1:0] pend_eff;
    logic                hazard;
    logic                stall;
    logic                issue;

    // Writeback clears its bit in the same cycle so a dependent instruction is released immediately.
    always_comb begin
        clr = '0;
        if (bus.wb_valid) clr[bus.wb_addr] = 1'b1;
        pend_eff = pending_q & ~clr;
        hazard = pend_eff[bus.id_rs]
               | (bus.id_use_rt & pend_eff[bus.id_rt])
               | (bus.id_reg_write & pend_eff[bus.id_rd]);
        stall = bus.id_valid & (hazard | (state_q == DRAIN));
        issue = bus.id_valid & ~stall;
    end

    // New writer sets its bit after the clear, so an issue and writeback to the same register keep it pending.
    always_comb begin
        set = '0;
        if (issue && bus.id_reg_write && bus.id_rd != '0) set[bus.id_rd] = 1'b1;
        pending_d = pend_eff | set;
        outstanding_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            outstanding_d = outstanding_d + {{ADDR_W{1'b0}}, pending_d[i]};
        end
        stall_cycles_d = stall_cycles_q;
        if (stall && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // Drain sequencing: block issue until every outstanding write has retired, then pulse done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.drain_req) state_d = DRAIN;
            DRAIN:   if (pend_eff == '0) state_d = DONE;
            DONE:    state_d = bus.drain_req ? DRAIN : RUN;
            default: state_d = RUN;
        endcase
        drain_done_d = (state_d == DONE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            pending_q      <= '0;
            outstanding_q  <= '0;
            drain_done_q   <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            outstanding_q  <= outstanding_d;
            drain_done_q   <= drain_done_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.id_issue     = issue;
    assign bus.id_stall     = stall;
    assign bus.pending      = pending_q;
    assign bus.outstanding  = outstanding_q;
    assign bus.drain_done   = drain_done_q;
    assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// tb/tb_decode_hazard_scoreboard.sv - directed self-checking bench for decode_hazard_scoreboard
module tb_decode_hazard_scoreboard;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    decode_hazard_scoreboard_if #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(16)) bus ();

    decode_hazard_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_use_rt    = 1'b0;
        bus.id_rd        = '0;
        bus.id_reg_write = 1'b0;
        bus.wb_valid     = 1'b0;
        bus.wb_addr      = '0;
        bus.drain_req    = 1'b0;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        idle();
        bus.id_valid     = 1'b1;
        bus.id_rd        = rd;
        bus.id_reg_write = 1'b1;
    endtask

    task automatic wb(input logic [4:0] a);
        idle();
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();

        // Reset with random inputs
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.id_valid     = 1'($urandom);
            bus.id_rs        = 5'($urandom);
            bus.id_rt        = 5'($urandom);
            bus.id_use_rt    = 1'($urandom);
            bus.id_rd        = 5'($urandom);
            bus.id_reg_write = 1'($urandom);
            bus.wb_valid     = 1'($urandom);
            bus.wb_addr      = 5'($urandom);
            bus.drain_req    = 1'($urandom);
            step();
        end
        reset = 1'b0;
        idle();
        sample();
        check("rst_pending", 64'(bus.pending), 64'h0);
        check("rst_outstanding", 64'(bus.outstanding), 64'h0);
        check("rst_drain_done", 64'(bus.drain_done), 64'h0);
        check("rst_stall_cycles", 64'(bus.stall_cycles), 64'h0);
        check("rst_issue", 64'(bus.id_issue), 64'h0);
        check("rst_stall", 64'(bus.id_stall), 64'h0);

        // RAW and zero-cycle release
        step();
        issue_rd(5'd3);
        sample();
        check("raw_c0_issue", 64'(bus.id_issue), 64'h1);
        step();
        idle();
        bus.id_valid = 1'b1;
        bus.id_rs    = 5'd3;
        sample();
        check("raw_c1_stall", 64'(bus.id_stall), 64'h1);
        check("raw_c1_pending", 64'(bus.pending), 64'h8);
        check("raw_c1_outstanding", 64'(bus.outstanding), 64'h1);
        step();
        sample();
        check("raw_c2_stall", 64'(bus.id_stall), 64'h1);
        step();
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd3;
        sample();
        check("raw_c3_issue", 64'(bus.id_issue), 64'h1);
        check("raw_c3_stall", 64'(bus.id_stall), 64'h0);
        step();
        idle();
        sample();
        check("raw_c4_pending", 64'(bus.pending), 64'h0);
        check("raw_c4_outstanding", 64'(bus.outstanding), 64'h0);
        check("raw_stall_cycles", 64'(bus.stall_cycles), 64'h2);

        // Register 0 is never tracked; unused rt does not stall
        step();
        issue_rd(5'd0);
        sample();
        check("r0_issue", 64'(bus.id_issue), 64'h1);
        step();
        issue_rd(5'd7);
        sample();
        check("r0_pending", 64'(bus.pending), 64'h0);
        step();
        idle();
        bus.id_valid  = 1'b1;
        bus.id_rt     = 5'd7;
        bus.id_use_rt = 1'b1;
        sample();
        check("rt_used_stall", 64'(bus.id_stall), 64'h1);
        bus.id_use_rt = 1'b0;
        #1;
        check("rt_unused_stall", 64'(bus.id_stall), 64'h0);
        check("rt_unused_issue", 64'(bus.id_issue), 64'h1);
        step();
        wb(5'd12);
        sample();
        check("wb_nonpend_pending", 64'(bus.pending), 64'h80);
        step();
        wb(5'd7);
        step();
        idle();
        sample();
        check("wb7_pending", 64'(bus.pending), 64'h0);
        check("r0_stall_cycles", 64'(bus.stall_cycles), 64'h2);

        // WAW stall, then same-cycle writeback and reissue keeps the bit
        step();
        issue_rd(5'd5);
        step();
        issue_rd(5'd5);
        sample();
        check("waw_pending", 64'(bus.pending), 64'h20);
        check("waw_stall", 64'(bus.id_stall), 64'h1);
        step();
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd5;
        sample();
        check("waw_wb_issue", 64'(bus.id_issue), 64'h1);
        step();
        idle();
        sample();
        check("waw_keep_pending", 64'(bus.pending), 64'h20);
        check("waw_keep_outstanding", 64'(bus.outstanding), 64'h1);
        check("waw_stall_cycles", 64'(bus.stall_cycles), 64'h3);
        step();
        wb(5'd5);
        step();
        idle();

        // Drain with regs 4 and 9 pending; writebacks in cycles 5 and 8
        issue_rd(5'd4);
        step();
        issue_rd(5'd9);
        step();
        idle();
        bus.drain_req = 1'b1;
        sample();
        check("drn_outstanding", 64'(bus.outstanding), 64'h2);
        for (int c = 3; c <= 8; c++) begin
            step();
            idle();
            bus.id_valid = 1'b1;
            bus.id_rs    = 5'd1;
            if (c == 5) begin bus.wb_valid = 1'b1; bus.wb_addr = 5'd4; end
            if (c == 8) begin bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; end
            sample();
            check($sformatf("drn_c%0d_stall", c), 64'(bus.id_stall), 64'h1);
            check($sformatf("drn_c%0d_done", c), 64'(bus.drain_done), 64'h0);
        end
        step();
        idle();
        bus.id_valid = 1'b1;
        bus.id_rs    = 5'd1;
        sample();
        check("drn_c9_done", 64'(bus.drain_done), 64'h1);
        check("drn_c9_issue", 64'(bus.id_issue), 64'h1);
        check("drn_c9_pending", 64'(bus.pending), 64'h0);
        step();
        sample();
        check("drn_c10_done", 64'(bus.drain_done), 64'h0);
        check("drn_c10_issue", 64'(bus.id_issue), 64'h1);
        check("drn_stall_cycles", 64'(bus.stall_cycles), 64'h9);

        // Reset while draining with two registers pending
        step();
        issue_rd(5'd2);
        step();
        issue_rd(5'd6);
        step();
        idle();
        bus.drain_req = 1'b1;
        step();
        idle();
        bus.id_valid = 1'b1;
        sample();
        check("mrst_in_drain_stall", 64'(bus.id_stall), 64'h1);
        check("mrst_outstanding", 64'(bus.outstanding), 64'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.id_rs = 5'd2;
        sample();
        check("mrst_issue", 64'(bus.id_issue), 64'h1);
        check("mrst_pending", 64'(bus.pending), 64'h0);
        check("mrst_outstanding0", 64'(bus.outstanding), 64'h0);
        check("mrst_done", 64'(bus.drain_done), 64'h0);
        check("mrst_stall_cycles", 64'(bus.stall_cycles), 64'h0);
        step();
        idle();
        sample();
        check("mrst_done_next", 64'(bus.drain_done), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
